// File: rtl/bin2oh_pkg.sv
// Shared types and helpers for the bin2onehot_stream decoder and its skid buffer.
package bin2oh_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERMO = ~MODE_ONEHOT;

    // Constant-evaluable ceil(log2(n)); usable in parameter defaults.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2oh_decode.sv
// Combinational binary index to one-hot (or thermometer) decoder with range error.
// Thermometer lanes exist only when BIN2OH_THERMO_EN is defined.
module bin2oh_decode
    import bin2oh_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int BIN_W = clog2(OUT_W)
) (
    input  logic [BIN_W-1:0] bin,
    input  logic             mode,
    output logic [OUT_W-1:0] vec,
    output logic             err
);

    logic [BIN_W:0] bin_ext;

    assign bin_ext = {1'b0, bin};
    assign err     = (bin_ext >= (BIN_W + 1)'(OUT_W));

`ifdef BIN2OH_THERMO_EN
    logic thermo;
    assign thermo = (mode == MODE_THERMO);
`else
    logic unused_mode;
    assign unused_mode = (mode == MODE_THERMO);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_lane
            localparam logic [BIN_W:0] IDX = (BIN_W + 1)'(gi);
`ifdef BIN2OH_THERMO_EN
            // Out-of-range would otherwise light every thermometer lane.
            assign vec[gi] = !err && (thermo ? (bin_ext >= IDX) : (bin_ext == IDX));
`else
            assign vec[gi] = (bin_ext == IDX);
`endif
        end
    endgenerate

endmodule

// File: rtl/bin2onehot_stream.sv
// Streaming binary-to-one-hot decoder with a 2-entry skid buffer (main + skid).
// Define BIN2OH_THERMO_EN to enable per-transaction thermometer mode via in_mode.
module bin2onehot_stream
    import bin2oh_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int BIN_W = clog2(OUT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vec,
    output logic             out_err
);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] main_vec_q;
    logic             main_err_q;
    logic [OUT_W-1:0] skid_vec_q;
    logic             skid_err_q;

    logic [OUT_W-1:0] dec_vec;
    logic             dec_err;
    logic             in_fire;
    logic             out_fire;

    // Mode is folded into the decoded vector here, so it rides the buffer with the data.
    bin2oh_decode #(
        .OUT_W (OUT_W),
        .BIN_W (BIN_W)
    ) u_decode (
        .bin  (in_bin),
        .mode (in_mode),
        .vec  (dec_vec),
        .err  (dec_err)
    );

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_vec_q  <= '0;
            main_err_q  <= 1'b0;
            skid_vec_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_vec_q  <= dec_vec;
                        main_err_q  <= dec_err;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_vec_q <= dec_vec;
                        skid_err_q <= dec_err;
                        in_ready_q <= 1'b0;
                        state_q    <= FULL;
                    end else if (in_fire && out_fire) begin
                        main_vec_q <= dec_vec;
                        main_err_q <= dec_err;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_vec_q <= skid_vec_q;
                        main_err_q <= skid_err_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_vec   = main_vec_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_bin2onehot_stream.sv
// Scoreboard bench: a 16-lane and a 10-lane instance share one stimulus stream.
module tb_bin2onehot_stream;

    localparam int W_A = 16;
    localparam int W_B = 10;
    localparam int BW  = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_mode   = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] in_bin    = '0;

    logic           a_in_ready, a_out_valid, a_out_err;
    logic [W_A-1:0] a_out_vec;
    logic           b_in_ready, b_out_valid, b_out_err;
    logic [W_B-1:0] b_out_vec;

    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b1;

    // Expected {err, vec[15:0]} per accepted input, oldest first.
    logic [16:0] qa[$];
    logic [16:0] qb[$];

    always #5 clk = ~clk;

    bin2onehot_stream #(.OUT_W(W_A), .BIN_W(BW)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_bin    (in_bin),
        .in_mode   (in_mode),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_vec   (a_out_vec),
        .out_err   (a_out_err)
    );

    bin2onehot_stream #(.OUT_W(W_B), .BIN_W(BW)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_bin    (in_bin),
        .in_mode   (in_mode),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_vec   (b_out_vec),
        .out_err   (b_out_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the rules: bit b set, or bits 0..b set, or nothing plus err.
    function automatic logic [16:0] model(input int b, input logic mode, input int w);
        logic        thermo;
        logic [31:0] v;
`ifdef BIN2OH_THERMO_EN
        thermo = mode;
`else
        thermo = mode && 1'b0;
`endif
        if (b >= w) return 17'h10000;
        v = thermo ? ((32'd1 << (b + 1)) - 32'd1) : (32'd1 << b);
        return {1'b0, v[15:0]};
    endfunction

    bit          stall_a = 1'b0;
    logic [16:0] hold_a;
    always @(negedge clk) begin
        logic [16:0] exp;
        if (!rst_n) begin
            stall_a = 1'b0;
        end else begin
            check("a_out_valid_vs_occupancy", 32'(a_out_valid), 32'(qa.size() != 0));
            check("a_in_ready_vs_occupancy", 32'(a_in_ready), 32'(qa.size() < 2));
            if (stall_a) check("a_hold_while_stalled", {a_out_valid, a_out_err, a_out_vec}, {1'b1, hold_a});
            stall_a = a_out_valid && !out_ready;
            hold_a  = {a_out_err, a_out_vec};
            if (a_out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_extra_output: got vec 0x%0h, required no output", a_out_vec);
                end else begin
                    exp = qa.pop_front();
                    check("a_out", {a_out_err, a_out_vec}, exp);
                    if (verbose) $display("a xfer vec=0x%04h err=%0b", a_out_vec, a_out_err);
                end
            end
            if (in_valid && a_in_ready) qa.push_back(model(int'(in_bin), in_mode, W_A));
        end
    end

    bit          stall_b = 1'b0;
    logic [16:0] hold_b;
    always @(negedge clk) begin
        logic [16:0] exp;
        if (!rst_n) begin
            stall_b = 1'b0;
        end else begin
            check("b_out_valid_vs_occupancy", 32'(b_out_valid), 32'(qb.size() != 0));
            check("b_in_ready_vs_occupancy", 32'(b_in_ready), 32'(qb.size() < 2));
            if (stall_b) check("b_hold_while_stalled", {b_out_valid, b_out_err, 6'b0, b_out_vec}, {1'b1, hold_b});
            stall_b = b_out_valid && !out_ready;
            hold_b  = {b_out_err, 6'b0, b_out_vec};
            if (b_out_valid && out_ready) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_extra_output: got vec 0x%0h, required no output", b_out_vec);
                end else begin
                    exp = qb.pop_front();
                    check("b_out", {b_out_err, 6'b0, b_out_vec}, exp);
                    if (verbose) $display("b xfer vec=0x%03h err=%0b", b_out_vec, b_out_err);
                end
            end
            if (in_valid && b_in_ready) qb.push_back(model(int'(in_bin), in_mode, W_B));
        end
    end

    // Present one input and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input int b, input logic m);
        int waited;
        in_valid = 1'b1;
        in_bin   = b[BW-1:0];
        in_mode  = m;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!a_in_ready && waited < 50);
        if (!a_in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, required 1", waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit accepted;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(a_out_valid), 32'd0);
        check("reset_out_vec", 32'(a_out_vec), 32'd0);
        check("reset_out_err", 32'(a_out_err), 32'd0);
        check("reset_in_ready", 32'(a_in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream, first output one cycle after the first accept.
        out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            send(b, 1'b0);
            check("stream_valid", 32'(a_out_valid), 32'd1);
            check("stream_vec", 32'(a_out_vec), 32'd1 << b);
            check("stream_err", 32'(a_out_err), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        // Skid fill under back-pressure, then drain.
        out_ready = 1'b0;
        send(5, 1'b0);
        send(9, 1'b0);
        check("skid_in_ready_low", 32'(a_in_ready), 32'd0);
        check("skid_main_vec", 32'(a_out_vec), 32'h0020);
        repeat (2) @(posedge clk);
        #1;
        check("skid_hold_vec", 32'(a_out_vec), 32'h0020);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("skid_drain_vec", 32'(a_out_vec), 32'h0200);
        check("skid_in_ready_back", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("skid_empty", 32'(a_out_valid), 32'd0);

        // Out-of-range on the 10-lane instance.
        send(12, 1'b0);
        check("w10_oor_vec", 32'(b_out_vec), 32'h000);
        check("w10_oor_err", 32'(b_out_err), 32'd1);
        send(9, 1'b0);
        check("w10_top_vec", 32'(b_out_vec), 32'h200);
        check("w10_top_err", 32'(b_out_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;

`ifdef BIN2OH_THERMO_EN
        send(3, 1'b1);
        check("thermo_vec", 32'(a_out_vec), 32'h000F);
        send(3, 1'b0);
        check("onehot_after_thermo", 32'(a_out_vec), 32'h0008);
        repeat (2) @(posedge clk);
        #1;
`endif

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        send(1, 1'b0);
        send(7, 1'b0);
        check("pre_reset_full", 32'(a_in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(a_out_valid), 32'd0);
        check("async_reset_out_vec", 32'(a_out_vec), 32'd0);
        check("async_reset_in_ready", 32'(a_in_ready), 32'd1);
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(2, 1'b0);
        check("post_reset_vec", 32'(a_out_vec), 32'h0004);
        check("post_reset_valid", 32'(a_out_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Random handshake stress; source holds data until accepted.
        verbose = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            accepted = in_valid && a_in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_bin   = BW'($urandom_range(0, 15));
                in_mode  = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("a_drained_all", 32'(qa.size()), 32'd0);
        check("b_drained_all", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
